// File: rtl/hit_detector.sv
// Debounces the raw GPIO box code into single-cycle hit events, compares each hit with the lit target box and optionally scores matches.
// Latency: hit_pulse follows DEBOUNCE_CYCLES+2 cycles of stable input; all outputs are registered. Optional scoring macro: HIT_SCORE_EN.
module hit_detector #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [2:0] box_address,
    input  logic [2:0] target_box,
    input  logic       target_valid,
    output logic       hit_pulse,
    output logic [2:0] hit_box,
    output logic       hit_match,
    output logic       busy,
    output logic [7:0] score
);

    typedef enum logic [1:0] {IDLE, SETTLE, FIRE, HOLD} state_t;

    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [2:0]       sync_meta;
    logic [2:0]       sync;
    logic [2:0]       cand;
    logic [CNT_W-1:0] cnt;

    // Box bits are synchronized independently; skew is absorbed because acceptance needs a stable code.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync_meta <= 3'd0;
            sync      <= 3'd0;
        end else begin
            sync_meta <= box_address;
            sync      <= sync_meta;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= 3'd0;
            cnt       <= '0;
            hit_pulse <= 1'b0;
            hit_box   <= 3'd0;
            hit_match <= 1'b0;
            busy      <= 1'b0;
        end else begin
            hit_pulse <= 1'b0;
            hit_match <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync != 3'd0) begin
                        cand  <= sync;
                        cnt   <= CNT_ONE;
                        state <= SETTLE;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (sync == 3'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (sync == cand) begin
                        if (cnt == DB_LIMIT) begin
                            state     <= FIRE;
                            hit_pulse <= 1'b1;
                            hit_box   <= cand;
                            hit_match <= target_valid && (target_box == cand) && (target_box != 3'd0);
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else begin
                        cand <= sync;
                        cnt  <= CNT_ONE;
                    end
                end
                FIRE: begin
                    state <= HOLD;
                    cnt   <= '0;
                end
                HOLD: begin
                    // Any non-zero code, even a different box, restarts the release wait.
                    if (sync != 3'd0) begin
                        cnt <= '0;
                    end else if (cnt == DB_LIMIT) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef HIT_SCORE_EN
    logic [7:0] score_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            score_q <= 8'd0;
        end else if (hit_pulse && hit_match && (score_q != 8'hFF)) begin
            score_q <= score_q + 8'd1;
        end
    end

    assign score = score_q;
`else
    assign score = 8'd0;
`endif

endmodule
